shift_seq: RTL and testbench

Multi-cycle shift engine for the NPC execute stage, handshake-driven counterpart to the single-cycle combinational barrel shifter. It accepts an operand, shift amount and function code on a valid/ready request port. It iterates STEP_BITS bit positions per cycle and returns the result on a valid/ready response port. It trades latency for area on configurations that drop the barrel shifter, and shares the same function encoding so the decoder drives either unit unchanged.

---
 rtl/shift_pkg.sv | 33 +++
 rtl/shift_step.sv | 58 +++++
 rtl/shift_seq.sv | 138 +++++++++++++
 tb/tb_shift_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the multi-cycle shift engine.
//
// The function codes are shared by the instruction decoder, the single-cycle
// combinational shifter and shift_seq, so either shifter can be driven by the
// decoder unchanged.
//
// Contents:
//   SH_SLL / SH_SRL / SH_SRA / SH_ROR  2-bit function codes
//   shift_state_t                      sequencer state (IDLE, RUN, DONE)
//   DataWidth / AmtWidth               operand and shift-amount widths
//   min_amt()                          smaller of two shift amounts
package shift_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AmtWidth  = 5;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b11;
  localparam logic [1:0] SH_ROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } shift_state_t;

  function automatic logic [AmtWidth-1:0] min_amt(input logic [AmtWidth-1:0] a,
                                                 input logic [AmtWidth-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational shift stage of the multi-cycle shift engine.
//
// Shifts data_i by amt_i positions according to fn_i. SRA fills with the
// externally supplied sign_i rather than data_i[31], so a multi-step SRA keeps
// replicating the original operand's sign no matter what the partially
// shifted MSB currently holds.
//
// Configuration macro: SHIFT_SEQ_ROTATE_EN
//   defined   : SH_ROR rotates right.
//   undefined : SH_ROR yields zero.
//
// Ports:
//   data_i  [31:0]  data to shift
//   amt_i   [4:0]   shift amount for this stage
//   fn_i    [1:0]   function code (SH_SLL/SH_SRL/SH_SRA/SH_ROR)
//   sign_i          fill bit for SRA
//   data_o  [31:0]  shifted data
module shift_step
  import shift_pkg::*;
(
  input  logic [DataWidth-1:0] data_i,
  input  logic [AmtWidth-1:0]  amt_i,
  input  logic [1:0]           fn_i,
  input  logic                 sign_i,
  output logic [DataWidth-1:0] data_o
);

  logic [DataWidth-1:0] srl_val;
  logic [DataWidth-1:0] fill_mask;

  assign srl_val   = data_i >> amt_i;
  // Ones in the top amt_i bit positions: the bits vacated by a right shift.
  assign fill_mask = ~({DataWidth{1'b1}} >> amt_i);

`ifdef SHIFT_SEQ_ROTATE_EN
  logic [5:0]           rot_back;
  logic [DataWidth-1:0] ror_val;

  // A left shift by 32 (amt_i == 0) yields zero, so no special case needed.
  assign rot_back = 6'd32 - {1'b0, amt_i};
  assign ror_val  = srl_val | (data_i << rot_back);
`endif

  always_comb begin
    data_o = '0;
    unique case (fn_i)
      SH_SLL: data_o = data_i << amt_i;
      SH_SRL: data_o = srl_val;
      SH_SRA: data_o = srl_val | (fill_mask & {DataWidth{sign_i}});
`ifdef SHIFT_SEQ_ROTATE_EN
      SH_ROR: data_o = ror_val;
`else
      SH_ROR: data_o = '0;
`endif
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift engine for the NPC execute stage.
//
// Accepts an operand, shift amount and function code on a valid/ready request
// port, shifts STEP_BITS positions per RUN cycle and presents the result on a
// valid/ready response port. Latency from accept to first out_valid is
// 1 + ceil(in_y / STEP_BITS) cycles. Operations never overlap.
//
// Configuration macro: SHIFT_SEQ_ROTATE_EN
//   defined   : fn 2'b10 rotates right, same latency rule as the shifts.
//   undefined : fn 2'b10 returns zero with a latency of one cycle.
//
// Parameters:
//   STEP_BITS  bit positions per RUN cycle; legal values 1, 2, 4, 8, 16
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort; wins over in_valid and out_ready
//   in_valid   request valid
//   in_ready   request ready (IDLE only)
//   in_x       [31:0] operand
//   in_y       [4:0]  shift amount
//   in_fn      [1:0]  function code
//   out_valid  result valid (DONE only)
//   out_ready  result consumed
//   out_data   [31:0] result, held stable while stalled
//   busy       high in RUN or DONE
module shift_seq
  import shift_pkg::*;
#(
  parameter int unsigned STEP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_x,
  input  logic [AmtWidth-1:0]  in_y,
  input  logic [1:0]           in_fn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 busy
);

  localparam logic [AmtWidth-1:0] StepMax = AmtWidth'(STEP_BITS);

  shift_state_t         state_q, state_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [AmtWidth-1:0]  rem_q, rem_d;
  logic [1:0]           fn_q, fn_d;
  logic                 sign_q, sign_d;

  logic [AmtWidth-1:0]  step_amt;
  logic [AmtWidth-1:0]  rem_next;
  logic [DataWidth-1:0] step_data;

  // The final step may be shorter than STEP_BITS.
  assign step_amt = min_amt(rem_q, StepMax);
  assign rem_next = rem_q - step_amt;

  shift_step u_shift_step (
    .data_i (data_q),
    .amt_i  (step_amt),
    .fn_i   (fn_q),
    .sign_i (sign_q),
    .data_o (step_data)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    fn_d    = fn_q;
    sign_d  = sign_q;

    if (flush) begin
      // Abort discards the result; a request presented with flush is dropped.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d = in_x;
            rem_d  = in_y;
            fn_d   = in_fn;
            sign_d = in_x[DataWidth-1];
`ifndef SHIFT_SEQ_ROTATE_EN
            // Match the combinational shifter: code 2'b10 is zero, no RUN phase.
            if (in_fn == SH_ROR) begin
              data_d = '0;
              rem_d  = '0;
            end
`endif
            state_d = (rem_d == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          data_d = step_data;
          rem_d  = rem_next;
          if (rem_next == '0) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      fn_q    <= SH_SLL;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      fn_q    <= fn_d;
      sign_q  <= sign_d;
    end
  end

  // Pure state decodes: no combinational path from any input.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_x = '0;
  logic [4:0]  in_y = '0;
  logic [1:0]  in_fn = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_seq #(.STEP_BITS(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_fn     (in_fn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Reference: whole-operation result straight from the function definitions.
  function automatic logic [31:0] ref_result(input logic [31:0] x, input logic [4:0] y,
                                             input logic [1:0] fn);
    logic [31:0] r;
    case (fn)
      2'b00: r = x << y;
      2'b01: r = x >> y;
      2'b11: r = 32'($signed(x) >>> y);
      default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
        r = x;
        for (int i = 0; i < int'(y); i++) r = {r[0], r[31:1]};
`else
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [4:0] y, input logic [1:0] fn);
`ifndef SHIFT_SEQ_ROTATE_EN
    if (fn == 2'b10) return 1;
`endif
    return 1 + (int'(y) + int'(STEP) - 1) / int'(STEP);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input logic [31:0] x, input logic [4:0] y, input logic [1:0] fn,
                        input int hold, input string name);
    logic [31:0] exp_d;
    int          exp_l;
    int          n;
    logic        ready_bad;
    logic [31:0] held;
    exp_d = ref_result(x, y, fn);
    exp_l = ref_latency(y, fn);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_at_start: in_ready=%b required 1", name, in_ready);
    end
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_fn     = fn;
    out_ready = (hold == 0);
    n = 0;
    ready_bad = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        in_valid = 1'b0;
        in_x     = $urandom;
      end
      if (out_valid === 1'b1 || n >= 100) break;
      if (in_ready !== 1'b0) ready_bad = 1'b1;
    end
    tests++;
    if (n != exp_l || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s latency: got %0d (out_valid=%b) required %0d", name, n, out_valid, exp_l);
    end
    tests++;
    if (out_data !== exp_d) begin
      fails++;
      $display("FAIL %s data: got %h required %h", name, out_data, exp_d);
    end
    tests++;
    if (ready_bad || in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_window: in_ready=%b busy=%b ready_glitch=%b required 0/1/0",
               name, in_ready, busy, ready_bad);
    end
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_x     = $urandom;
      in_y     = 5'($urandom);
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold%0d: valid=%b data=%h ready=%b required 1/%h/0",
                 name, i, out_valid, out_data, in_ready, held);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s consumed: ready=%b valid=%b busy=%b required 1/0/0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL %s: ready=%b valid=%b busy=%b data=%h required 1/0/0/00000000",
               name, in_ready, out_valid, busy, out_data);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL %s: activity seen after abort, required idle", name);
    end
  endtask

  // Accept SLL y=20 and stop at the negedge of the third RUN cycle.
  task automatic start_long_op();
    in_valid = 1'b1;
    in_x     = 32'hDEAD_BEEF;
    in_y     = 5'd20;
    in_fn    = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_directed();
    run_op(32'h8000_0001, 5'd4,  2'b00, 0, "sll_y4");
    run_op(32'h8000_0000, 5'd31, 2'b11, 0, "sra_y31");
    run_op(32'h8000_0000, 5'd31, 2'b01, 0, "srl_y31");
    run_op(32'hF000_0000, 5'd5,  2'b11, 0, "sra_y5_partial_step");
    run_op(32'h0000_00F1, 5'd4,  2'b10, 0, "fn10_y4");
    run_op(32'h0000_00F1, 5'd31, 2'b10, 0, "fn10_y31");
  endtask

  task automatic test_back_to_back();
    run_op(32'h1234_5678, 5'd0, 2'b01, 0, "srl_y0");
    run_op(32'h1234_5678, 5'd0, 2'b11, 0, "b2b_sra_y0");
    run_op(32'hCAFE_F00D, 5'd9, 2'b00, 0, "b2b_sll_y9");
  endtask

  task automatic test_hold();
    run_op(32'h8765_4321, 5'd7, 2'b11, 3, "hold3");
  endtask

  task automatic test_flush();
    start_long_op();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_x     = 32'h5555_5555;
    in_y     = 5'd3;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_to_idle: ready=%b valid=%b busy=%b required 1/0/0",
               in_ready, out_valid, busy);
    end
    expect_quiet(12, "flush_quiet");
    run_op(32'h0F0F_0F0F, 5'd20, 2'b00, 0, "after_flush");
  endtask

  task automatic test_reset_mid();
    start_long_op();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(8, "reset_run_quiet");
    in_valid  = 1'b1;
    in_x      = 32'hABCD_0123;
    in_y      = 5'd0;
    in_fn     = 2'b01;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h8000_0001, 5'd4, 2'b00, 0, "after_reset");
  endtask

  task automatic test_random();
    int   holds[5] = '{0, 0, 0, 1, 2};
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, 5'($urandom), 2'($urandom), holds[$urandom_range(0, 4)], "random");
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
